inst_queue: RTL and testbench



---
 rtl/inst_queue.sv | 132 +++++++++++++
 tb/tb_inst_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// inst_queue: instruction buffer between fetch and decode.
// Accepts up to IN_WIDTH fetched instructions per cycle (leading run of
// in_valid only) and presents the OUT_WIDTH oldest entries in program order.
// Ports:
//   clk, reset (sync, active-high), flush (discard all entries)
//   in_valid/in_pc/in_inst/in_pred_taken/in_pred_target/in_excp/in_excp_code
//     fetch slots, slot k at bits [k*W +: W]
//   in_ready  : room for a full IN_WIDTH push (based on current count only)
//   out_valid/out_pc/out_inst/out_pred_taken/out_pred_target/out_excp/
//   out_excp_code : entry at head+k on slot k
//   out_num   : entries consumed by decode this cycle (clamped to count)
//   count     : current occupancy
module inst_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2,
  parameter int unsigned EXCP_W    = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [IN_WIDTH-1:0]              in_valid,
  input  logic [32*IN_WIDTH-1:0]           in_pc,
  input  logic [32*IN_WIDTH-1:0]           in_inst,
  input  logic [IN_WIDTH-1:0]              in_pred_taken,
  input  logic [32*IN_WIDTH-1:0]           in_pred_target,
  input  logic [IN_WIDTH-1:0]              in_excp,
  input  logic [EXCP_W*IN_WIDTH-1:0]       in_excp_code,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_valid,
  output logic [32*OUT_WIDTH-1:0]          out_pc,
  output logic [32*OUT_WIDTH-1:0]          out_inst,
  output logic [OUT_WIDTH-1:0]             out_pred_taken,
  output logic [32*OUT_WIDTH-1:0]          out_pred_target,
  output logic [OUT_WIDTH-1:0]             out_excp,
  output logic [EXCP_W*OUT_WIDTH-1:0]      out_excp_code,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]   out_num,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam int unsigned NP_W  = $clog2(IN_WIDTH+1);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              excp;
    logic [EXCP_W-1:0] excp_code;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  entry_t             w_in  [IN_WIDTH];
  entry_t             w_out [OUT_WIDTH];
  logic [NP_W-1:0]    w_np;
  logic               w_run;
  logic [CNT_W-1:0]   w_nd;
  logic [CNT_W-1:0]   w_out_num;

  assign count    = r_count;
  assign in_ready = (r_count <= CNT_W'(DEPTH - IN_WIDTH));

  // Unpack fetch slots into entries
  always_comb begin
    for (int j = 0; j < IN_WIDTH; j++) begin
      w_in[j].pc          = in_pc[j*32 +: 32];
      w_in[j].inst        = in_inst[j*32 +: 32];
      w_in[j].pred_taken  = in_pred_taken[j];
      w_in[j].pred_target = in_pred_target[j*32 +: 32];
      w_in[j].excp        = in_excp[j];
      w_in[j].excp_code   = in_excp_code[j*EXCP_W +: EXCP_W];
    end
  end

  // Push count: length of the leading run of valid slots, zero when not ready
  always_comb begin
    w_np  = '0;
    w_run = 1'b1;
    for (int j = 0; j < IN_WIDTH; j++) begin
      if (w_run && in_valid[j]) w_np = w_np + NP_W'(1);
      else                      w_run = 1'b0;
    end
    if (!in_ready) w_np = '0;
  end

  // Pop count clamped to occupancy
  assign w_out_num = CNT_W'(out_num);
  assign w_nd      = (w_out_num > r_count) ? r_count : w_out_num;

  // Storage write; not reset, gated by reset/flush so discarded pushes never land
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int j = 0; j < IN_WIDTH; j++) begin
        if (j < int'(w_np)) r_mem[r_tail + PTR_W'(j)] <= w_in[j];
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_nd);
      r_tail  <= r_tail + PTR_W'(w_np);
      r_count <= r_count + CNT_W'(w_np) - w_nd;
    end
  end

  // Read the oldest OUT_WIDTH entries straight from storage
  always_comb begin
    for (int k = 0; k < OUT_WIDTH; k++) begin
      w_out[k]                           = r_mem[r_head + PTR_W'(k)];
      out_valid[k]                       = (r_count > CNT_W'(k));
      out_pc[k*32 +: 32]                 = w_out[k].pc;
      out_inst[k*32 +: 32]               = w_out[k].inst;
      out_pred_taken[k]                  = w_out[k].pred_taken;
      out_pred_target[k*32 +: 32]        = w_out[k].pred_target;
      out_excp[k]                        = w_out[k].excp;
      out_excp_code[k*EXCP_W +: EXCP_W]  = w_out[k].excp_code;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted instructions are queued in
// program order by the driver; a negedge monitor compares occupancy,
// readiness and the presented slots against that queue and retires the
// entries decode consumes.
module tb_inst_queue;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned IN_WIDTH  = 2;
  localparam int unsigned OUT_WIDTH = 2;
  localparam int unsigned EXCP_W    = 6;
  localparam int unsigned CNT_W     = $clog2(DEPTH+1);
  localparam int unsigned NUM_W     = $clog2(OUT_WIDTH+1);

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic              pt;
    logic [31:0]       tgt;
    logic              excp;
    logic [EXCP_W-1:0] code;
  } ent_t;

  logic                        clk = 1'b0;
  logic                        reset, flush;
  logic [IN_WIDTH-1:0]         in_valid;
  logic [32*IN_WIDTH-1:0]      in_pc, in_inst, in_pred_target;
  logic [IN_WIDTH-1:0]         in_pred_taken, in_excp;
  logic [EXCP_W*IN_WIDTH-1:0]  in_excp_code;
  logic                        in_ready;
  logic [OUT_WIDTH-1:0]        out_valid, out_pred_taken, out_excp;
  logic [32*OUT_WIDTH-1:0]     out_pc, out_inst, out_pred_target;
  logic [EXCP_W*OUT_WIDTH-1:0] out_excp_code;
  logic [NUM_W-1:0]            out_num;
  logic [CNT_W-1:0]            count;

  inst_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .EXCP_W(EXCP_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .in_excp(in_excp), .in_excp_code(in_excp_code),
    .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_pred_taken(out_pred_taken),
    .out_pred_target(out_pred_target), .out_excp(out_excp),
    .out_excp_code(out_excp_code), .out_num(out_num), .count(count)
  );

  always #5 clk = ~clk;

  ent_t        sb_q[$];     // reference queue: entries the DUT should hold, oldest first
  ent_t        pend_q[$];   // entries accepted this cycle, committed after the edge
  bit          pend_clr;
  bit          mon_en = 1'b0;
  bit          force_excp = 1'b0;
  logic [31:0] next_pc = 32'h1c00_0000;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; called 1 time unit after a rising edge.
  task automatic drive(input logic [IN_WIDTH-1:0] v, input int onum, input bit fl, input bit rst);
    int   sz;
    bit   rdy;
    int   np;
    ent_t e;
    sz  = sb_q.size();
    rdy = (int'(DEPTH) - sz) >= int'(IN_WIDTH);
    np  = 0;
    while (np < int'(IN_WIDTH) && v[np]) np++;
    if (!rdy) np = 0;
    for (int j = 0; j < int'(IN_WIDTH); j++) begin
      e.pc   = next_pc + 32'(4*j);
      e.inst = $urandom;
      e.pt   = 1'($urandom);
      e.tgt  = $urandom;
      e.excp = force_excp ? 1'b1 : 1'($urandom);
      e.code = EXCP_W'($urandom);
      in_pc[j*32 +: 32]              = e.pc;
      in_inst[j*32 +: 32]            = e.inst;
      in_pred_taken[j]               = e.pt;
      in_pred_target[j*32 +: 32]     = e.tgt;
      in_excp[j]                     = e.excp;
      in_excp_code[j*EXCP_W +: EXCP_W] = e.code;
      if (j < np) pend_q.push_back(e);
    end
    next_pc  = next_pc + 32'(4*np);
    in_valid = v;
    out_num  = NUM_W'(onum);
    flush    = fl;
    reset    = rst;
    pend_clr = fl | rst;
    @(posedge clk);
    #1;
    if (pend_clr) sb_q.delete();
    else foreach (pend_q[i]) sb_q.push_back(pend_q[i]);
    pend_q.delete();
  endtask

  // Monitor: compare presented state against the reference queue, retire consumed entries
  always @(negedge clk) begin : mon
    int sz;
    int nd;
    logic [OUT_WIDTH-1:0] ev;
    if (mon_en) begin
      sz = sb_q.size();
      check("count", 64'(count), 64'(sz));
      check("in_ready", 64'(in_ready), 64'((int'(DEPTH) - sz) >= int'(IN_WIDTH)));
      for (int k = 0; k < int'(OUT_WIDTH); k++) ev[k] = (k < sz);
      check("out_valid", 64'(out_valid), 64'(ev));
      for (int k = 0; k < int'(OUT_WIDTH) && k < sz; k++) begin
        check("out_pc", 64'(out_pc[k*32 +: 32]), 64'(sb_q[k].pc));
        check("out_inst", 64'(out_inst[k*32 +: 32]), 64'(sb_q[k].inst));
        check("out_pred_target", 64'(out_pred_target[k*32 +: 32]), 64'(sb_q[k].tgt));
        check("out_tags", 64'({out_pred_taken[k], out_excp[k], out_excp_code[k*EXCP_W +: EXCP_W]}),
              64'({sb_q[k].pt, sb_q[k].excp, sb_q[k].code}));
      end
      nd = (int'(out_num) < sz) ? int'(out_num) : sz;
      for (int k = 0; k < nd; k++) void'(sb_q.pop_front());
    end
  end

  task automatic drain();
    for (int i = 0; i < int'(DEPTH) && sb_q.size() != 0; i++) drive('0, OUT_WIDTH, 1'b0, 1'b0);
    check("drained", 64'(count), 64'(0));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = '0; out_num = '0;
    in_pc = '0; in_inst = '0; in_pred_target = '0;
    in_pred_taken = '0; in_excp = '0; in_excp_code = '0;
    #1;
    drive('0, 0, 1'b0, 1'b1);
    drive('0, 0, 1'b0, 1'b1);
    check("reset_count", 64'(count), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    mon_en = 1'b1;

    // Push and drain
    drive(2'b11, 0, 1'b0, 1'b0);
    check("pd_count", 64'(count), 64'(2));
    check("pd_pc0", 64'(out_pc[31:0]), 64'(32'h1c00_0000));
    check("pd_pc1", 64'(out_pc[63:32]), 64'(32'h1c00_0004));
    drive('0, 2, 1'b0, 1'b0);
    check("pd_drain", 64'(count), 64'(0));

    // Fill and hold
    repeat (8) drive(2'b11, 0, 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'(16));
    check("fill_ready", 64'(in_ready), 64'(0));
    drive(2'b11, 0, 1'b0, 1'b0);
    check("fill_hold", 64'(count), 64'(16));
    // Pop while full: in_ready reflects only the current count
    drive(2'b11, 2, 1'b0, 1'b0);
    check("full_pop", 64'(count), 64'(14));
    drain();

    // Simultaneous push and pop at count 4
    repeat (2) drive(2'b11, 0, 1'b0, 1'b0);
    repeat (6) begin
      drive(2'b11, 2, 1'b0, 1'b0);
      check("pushpop_count", 64'(count), 64'(4));
    end
    drain();

    // Wrap-around stream with alternating pop widths
    for (int i = 0; i < 20; i++) drive(2'b11, (i % 2 == 0) ? 1 : 2, 1'b0, 1'b0);
    drain();

    // Flush priority over push and pop
    repeat (3) drive(2'b11, 0, 1'b0, 1'b0);
    check("pre_flush", 64'(count), 64'(6));
    drive(2'b11, 2, 1'b1, 1'b0);
    check("flush_count", 64'(count), 64'(0));
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    drive(2'b11, 0, 1'b0, 1'b0);
    check("post_flush", 64'(count), 64'(2));
    drain();

    // Prefix rule, tag carry-through and pop clamping
    drive(2'b10, 0, 1'b0, 1'b0);
    check("prefix_none", 64'(count), 64'(0));
    force_excp = 1'b1;
    drive(2'b01, 0, 1'b0, 1'b0);
    force_excp = 1'b0;
    check("prefix_one", 64'(count), 64'(1));
    check("excp_flag", 64'(out_excp[0]), 64'(1));
    drive('0, 2, 1'b0, 1'b0);
    check("clamp", 64'(count), 64'(0));
    drive('0, 2, 1'b0, 1'b0);
    check("empty_pop", 64'(count), 64'(0));

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      drive(IN_WIDTH'($urandom), int'($urandom_range(0, OUT_WIDTH)), (r < 2), (r == 2));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
